instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Upstream sequencer for the non-pipelined MIPS core.
- Owns the PC and fetches each instruction from instruction memory over a req/ready handshake.
- Holds the instruction stable and presents opcode[31:26] to the registered control unit.
- Waits a fixed execute window, then computes the next PC from the control unit's jump/branch outputs and the ALU zero flag.

Parameters:
- ADDR_W, 32: PC and memory address width.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- EXEC_CYCLES, 2: cycles spent in EXEC before PC update; must be >= 1 (covers registered-control latency plus datapath settle).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_addr  out  ADDR_W  fetch address; equals pc.
- imem_ready  in  1  memory has valid imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  current instruction register.
- opcode  out  6  instr[31:26], to control unit.
- instr_valid  out  1  high in DECODE and EXEC.
- pc  out  ADDR_W  current PC.
- pc_plus4  out  ADDR_W  pc+4, for the jal link path.
- jump  in  1  from control unit.
- branch  in  1  from control unit.
- alu_zero  in  1  ALU zero flag.
- stall  in  1  freezes the EXEC countdown.
- retire  out  1  one-cycle pulse on PC update.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: state=IDLE, pc=RESET_PC, instr=32'h0, exec_cnt=0, retire=0. In IDLE, imem_req=0 and instr_valid=0.
- Reset asserted in any state, including mid-fetch or mid-EXEC, aborts the operation; no retire pulse is produced.
- States: IDLE, FETCH, DECODE, EXEC.
- IDLE -> FETCH: unconditionally, one cycle after reset deasserts.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ready.
  - On an edge with imem_ready=1: instr<=imem_rdata, go to DECODE.
  - No timeout; FETCH waits indefinitely.
- DECODE:
  - Lasts exactly one cycle; instr_valid=1.
  - The control unit registers the opcode at this edge.
  - exec_cnt<=EXEC_CYCLES-1, go to EXEC.
- EXEC:
  - instr_valid=1; instr is frozen.
  - stall=1 holds exec_cnt and state.
  - If exec_cnt!=0 and stall=0, decrement exec_cnt.
  - If exec_cnt==0 and stall=0: pc<=next_pc, retire=1 for that one cycle, go to FETCH.
  - jump, branch and alu_zero are sampled only on this final edge.
- next_pc, with jump taking priority over branch:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - Else branch=1 and alu_zero=1: pc_plus4 + (sign-extended instr[15:0] << 2).
  - Otherwise: pc_plus4.
  - All additions are modulo 2^ADDR_W and wrap without error, e.g. 32'hFFFF_FFFC + 4 = 32'h0.
- If jump=1 and branch=1 together, jump wins.
- Minimum instruction period = 1 (FETCH with immediate ready) + 1 (DECODE) + EXEC_CYCLES.
- imem_rdata is ignored outside FETCH; imem_ready is ignored outside FETCH.
- pc_plus4 is combinational from pc.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants OP_RTYPE=6'b000000, OP_J=6'b000010, OP_JAL=6'b000011, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100.
  - Fetch FSM state encoding (IDLE=2'd0, FETCH=2'd1, DECODE=2'd2, EXEC=2'd3).
  - Instruction field slice positions.
- Sub-module next_pc_calc (purely combinational):
  - Inputs: pc_plus4, instr, jump, branch, alu_zero.
  - Output: next_pc.
  - Instantiated once; unit-testable alone.

Test Plan:
- Reset/sequential: reset 2 cycles, imem_ready tied 1, memory returns add (opcode 0), jump=branch=0.
  - imem_req first high 1 cycle after reset release with addr 0x0.
  - retire pulses every 4 cycles (EXEC_CYCLES=2); pc steps 0x0 -> 0x4 -> 0x8.
- Fetch wait: imem_ready low 5 cycles at pc=0x10.
  - imem_req and imem_addr=0x10 held stable throughout; instr is updated only on the ready edge.
- Jump: pc=0x1000_0040, instr=32'h0800_0100, jump=1, branch=1 at final EXEC edge.
  - next pc=0x1000_0400 (jump priority).
- Branch: pc=0x20, instr imm=16'hFFFE, branch=1.
  - alu_zero=1 gives pc=0x1C.
  - alu_zero=0 gives pc=0x24.
- Stall and wrap: pc=32'hFFFF_FFFC, stall high 3 cycles in EXEC.
  - EXEC lasts 5 cycles total.
  - Single retire pulse; pc becomes 0x0.
- Reset mid-EXEC: assert reset while exec_cnt=1.
  - No retire pulse.
  - Next cycle pc=RESET_PC, state IDLE, instr_valid=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the non-pipelined MIPS core: opcodes, fetch FSM
// state encoding and instruction field positions.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_DECODE = 2'd2;
    localparam logic [1:0] ST_EXEC   = 2'd3;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int TARGET_HI = 25;
    localparam int IMM_HI    = 15;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump target, taken branch, or fall-through.
// Jump wins over branch; all arithmetic wraps modulo 2^ADDR_W.
module next_pc_calc
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [31:0]       instr,
    input  logic              jump,
    input  logic              branch,
    input  logic              alu_zero,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_off;

    // Region bits above the 28-bit jump field come from pc_plus4.
    assign jump_target = {pc_plus4[ADDR_W-1:28], instr[TARGET_HI:0], 2'b00};
    assign branch_off  = {{(ADDR_W-18){instr[IMM_HI]}}, instr[IMM_HI:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && alu_zero) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: owns the PC, fetches over imem_req/imem_ready, holds the
// instruction through DECODE/EXEC and updates the PC after a fixed EXEC window.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                EXEC_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              jump,
    input  logic              branch,
    input  logic              alu_zero,
    input  logic              stall,
    output logic              retire,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] EXEC_INIT = CNT_W'(EXEC_CYCLES - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  exec_cnt;
    logic [ADDR_W-1:0] next_pc;

    // Handshake: imem_req is held high with a stable imem_addr until a cycle
    // in which imem_ready is high; imem_rdata is captured on that edge only.
    assign imem_req    = (state == ST_FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == ST_DECODE) || (state == ST_EXEC);
    assign opcode      = instr[OPCODE_HI:OPCODE_LO];
    assign pc_plus4    = pc + ADDR_W'(4);
    assign dbg_state   = state;

    next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .jump     (jump),
        .branch   (branch),
        .alu_zero (alu_zero),
        .next_pc  (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            instr    <= 32'h0;
            exec_cnt <= '0;
            retire   <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                ST_IDLE: state <= ST_FETCH;
                ST_FETCH: begin
                    if (imem_ready) begin
                        instr <= imem_rdata;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    exec_cnt <= EXEC_INIT;
                    state    <= ST_EXEC;
                end
                ST_EXEC: begin
                    // Control inputs matter only on the edge that leaves EXEC.
                    if (!stall) begin
                        if (exec_cnt == '0) begin
                            pc     <= next_pc;
                            retire <= 1'b1;
                            state  <= ST_FETCH;
                        end else begin
                            exec_cnt <= exec_cnt - 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
